// File: rtl/spi_avr_bridge.sv
// SPI-slave (mode 0, MSB first) front end turning AVR frames into the FDC core strobe bus.
// Optional burst continuation (addr+1 per extra byte) is enabled by defining SPI_BURST_EN.
module spi_avr_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int SEL_TICKS   = 12
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [1:0]  intr,
    output logic [15:0] a_addrbus,
    inout  wire  [7:0]  a_databus,
    output logic        a_rw,
    output logic        a_sel
);
`ifdef SPI_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif
    localparam int TICK_W = $clog2(SEL_TICKS);

    typedef enum logic [3:0] {
        IDLE = 4'd0, CMD = 4'd1, ADDR_H = 4'd2, ADDR_L = 4'd3, WDATA = 4'd4,
        TURN = 4'd5, RDATA = 4'd6, STROBE = 4'd7, EXTRA = 4'd8
    } frame_t;
    typedef enum logic [1:0] {
        STB_IDLE = 2'd0, STB_SETUP = 2'd1, STB_LOW = 2'd2, STB_HOLD = 2'd3
    } stb_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic        sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
    logic        sck_s, cs_s, mosi_s, cs_active_s, sck_rise_s, sck_fall_s, cs_fall_s;
    logic        byte_done_s, load_s, stb_busy_s;
    logic [7:0]  rx_byte_s;
    frame_t      state_q, state_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        is_read_q, is_read_d, underrun_q, underrun_d, miso_oe_q, miso_oe_d;
    logic        launch_s, launch_rd_s;
    logic [15:0] launch_addr_s;
    logic [7:0]  launch_data_s;
    stb_t        stb_q, stb_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [15:0] a_addr_q, a_addr_d;
    logic [7:0]  a_data_q, a_data_d, rdbuf_q, rdbuf_d;
    logic        a_oe_q, a_oe_d, a_rw_q, a_rw_d, a_sel_q, a_sel_d;

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_active_s = ~cs_s;
    assign sck_rise_s  = cs_active_s & sck_s & ~sck_prev_q;
    assign sck_fall_s  = cs_active_s & ~sck_s & sck_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign rx_byte_s   = {rx_q, mosi_s};
    assign byte_done_s = sck_rise_s & (bit_cnt_q == 3'd7);
    // A falling edge right after a completed byte loads the next TX byte instead of shifting.
    assign load_s      = sck_fall_s & (bit_cnt_q == 3'd0) & (byte_cnt_q != 3'd0);
    assign stb_busy_s  = (stb_q != STB_IDLE);

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // Frame sequencing: advances one state per completed byte; CS high aborts.
    always_comb begin
        state_d = state_q;
        if (!cs_active_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = cs_fall_s ? CMD : IDLE;
                CMD:     state_d = byte_done_s ? ADDR_H : CMD;
                ADDR_H:  state_d = byte_done_s ? ADDR_L : ADDR_H;
                ADDR_L:  state_d = byte_done_s ? (is_read_q ? TURN : WDATA) : ADDR_L;
                WDATA:   state_d = byte_done_s ? (BURST_EN ? WDATA : STROBE) : WDATA;
                TURN:    state_d = byte_done_s ? RDATA : TURN;
                RDATA:   state_d = byte_done_s ? (BURST_EN ? RDATA : EXTRA) : RDATA;
                STROBE:  state_d = byte_done_s ? EXTRA : STROBE;
                EXTRA:   state_d = EXTRA;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_d          = rx_q;
        tx_d          = tx_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        addr_d        = addr_q;
        is_read_d     = is_read_q;
        underrun_d    = underrun_q;
        miso_oe_d     = cs_active_s;
        launch_s      = 1'b0;
        launch_rd_s   = 1'b0;
        launch_addr_s = addr_q;
        launch_data_s = rx_byte_s;
        if (cs_fall_s) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            tx_d       = {6'b000000, intr};
            underrun_d = 1'b0;
        end else if (sck_rise_s && state_q != IDLE) begin
            rx_d      = rx_byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done_s) begin
                byte_cnt_d = (byte_cnt_q == 3'd7) ? 3'd7 : byte_cnt_q + 3'd1;
                case (state_q)
                    CMD:    is_read_d = rx_byte_s[7];
                    ADDR_H: addr_d[15:8] = rx_byte_s;
                    ADDR_L: begin
                        addr_d[7:0]   = rx_byte_s;
                        launch_s      = is_read_q;
                        launch_rd_s   = 1'b1;
                        launch_addr_s = {addr_q[15:8], rx_byte_s};
                    end
                    WDATA: begin
                        launch_s = 1'b1;
                        addr_d   = BURST_EN ? addr_q + 16'd1 : addr_q;
                    end
                    default: addr_d = addr_q;
                endcase
            end else begin
                byte_cnt_d = byte_cnt_q;
            end
        end else if (load_s && state_q != IDLE) begin
            case (state_q)
                RDATA: begin
                    if (stb_busy_s) begin
                        tx_d       = 8'hEE;
                        underrun_d = 1'b1;
                    end else begin
                        // Burst reads prefetch the next address as soon as this byte is handed over.
                        tx_d          = rdbuf_q;
                        launch_s      = BURST_EN;
                        launch_rd_s   = 1'b1;
                        launch_addr_s = addr_q + 16'd1;
                        addr_d        = BURST_EN ? addr_q + 16'd1 : addr_q;
                    end
                end
                STROBE, EXTRA: tx_d = 8'hFF;
                default:       tx_d = 8'h00;
            endcase
        end else if (sck_fall_s) begin
            tx_d = {tx_q[6:0], 1'b0};
        end else begin
            tx_d = tx_q;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rx_q       <= 7'd0;
            tx_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            addr_q     <= 16'h0000;
            is_read_q  <= 1'b0;
            underrun_q <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            underrun_q <= underrun_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    // Strobe sequencer runs independently of the frame so an abort never truncates a_sel.
    always_comb begin
        case (stb_q)
            STB_IDLE:  stb_d = launch_s ? STB_SETUP : STB_IDLE;
            STB_SETUP: stb_d = STB_LOW;
            STB_LOW:   stb_d = (tick_q == '0) ? (a_rw_q ? STB_IDLE : STB_HOLD) : STB_LOW;
            STB_HOLD:  stb_d = STB_IDLE;
            default:   stb_d = STB_IDLE;
        endcase
    end

    always_comb begin
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        a_oe_d   = a_oe_q;
        a_rw_d   = a_rw_q;
        a_sel_d  = a_sel_q;
        tick_d   = tick_q;
        rdbuf_d  = rdbuf_q;
        case (stb_q)
            STB_IDLE: begin
                if (launch_s) begin
                    a_addr_d = launch_addr_s;
                    a_data_d = launch_data_s;
                    a_rw_d   = launch_rd_s;
                    a_oe_d   = ~launch_rd_s;
                end else begin
                    a_oe_d = a_oe_q;
                end
            end
            STB_SETUP: begin
                a_sel_d = 1'b0;
                tick_d  = TICK_W'(SEL_TICKS - 1);
            end
            STB_LOW: begin
                if (tick_q == '0) begin
                    a_sel_d = 1'b1;
                    rdbuf_d = a_rw_q ? a_databus : rdbuf_q;
                end else begin
                    tick_d = tick_q - TICK_W'(1);
                end
            end
            STB_HOLD: begin
                a_oe_d = 1'b0;
                a_rw_d = 1'b1;
            end
            default: a_sel_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            stb_q    <= STB_IDLE;
            tick_q   <= '0;
            a_addr_q <= 16'h0000;
            a_data_q <= 8'h00;
            a_oe_q   <= 1'b0;
            a_rw_q   <= 1'b1;
            a_sel_q  <= 1'b1;
            rdbuf_q  <= 8'h00;
        end else begin
            stb_q    <= stb_d;
            tick_q   <= tick_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            a_oe_q   <= a_oe_d;
            a_rw_q   <= a_rw_d;
            a_sel_q  <= a_sel_d;
            rdbuf_q  <= rdbuf_d;
        end
    end

    assign a_addrbus = a_addr_q;
    assign a_rw      = a_rw_q;
    assign a_sel     = a_sel_q;
    assign a_databus = a_oe_q ? a_data_q : 8'hzz;
    assign spi_miso  = miso_oe_q ? tx_q[7] : 1'bz;
endmodule
